// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the parametrised synchronous FIFO.
//   cnt_w()     - width of the occupancy counter (one more bit than the pointers,
//                 so a completely full FIFO is representable).
//   FWFT_OFF/ON - output mode encoding for the FWFT parameter.
//   params_ok() - elaboration-time sanity check of depth, thresholds and mode.
package fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    function automatic int cnt_w(input int depth_log2);
        return depth_log2 + 1;
    endfunction

    function automatic bit params_ok(input int depth_log2,
                                     input int af_thresh,
                                     input int ae_thresh,
                                     input int fwft);
        int depth;
        depth = 1 << depth_log2;
        return (depth_log2 >= 1) && (depth_log2 <= 10) &&
               (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh >= 0) && (ae_thresh < depth) &&
               ((fwft == FWFT_OFF) || (fwft == FWFT_ON));
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: 2**DEPTH_LOG2 x WIDTH storage for the FIFO.
// Ports:
//   clk     - clock
//   we_i    - write enable (synchronous write on rising edge)
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address (asynchronous read)
//   rdata_o - read data, combinational from raddr_i
// Contents are never reset.
module fifo_ram #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with configurable width/depth, occupancy
// count, almost-full/almost-empty thresholds and sticky error flags.
// Ports:
//   clk, reset_n       - clock, synchronous active-low reset
//   data_i, wr_en      - write data and write request
//   rd_en              - read request (standard) / pop of the head (FWFT)
//   clr_err            - clears ovf_sticky/udf_sticky (a coinciding error wins)
//   data_o, valid_o    - read data and its qualifier
//   full, empty        - occupancy at limit / zero
//   almost_full/_empty - count >= AF_THRESH / count <= AE_THRESH
//   count              - current occupancy
//   overflow/underflow - one-cycle pulse for a dropped write / rejected read
//   ovf_sticky/udf_sticky - latched versions of the pulses
//
// Handshake: a request is taken on a rising edge when it is accepted.
// rd is accepted when rd_en=1 and the FIFO is not empty (pre-edge state);
// wr is accepted when wr_en=1 and the FIFO is not full, or when a read is
// accepted on the same edge. Rejected requests change nothing except the
// error pulse/sticky flags. Status outputs come only from registered state.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 8,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = FWFT_OFF
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [WIDTH-1:0]               data_i,
    input  logic                           wr_en,
    input  logic                           rd_en,
    input  logic                           clr_err,
    output logic [WIDTH-1:0]               data_o,
    output logic                           valid_o,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic [cnt_w(DEPTH_LOG2)-1:0]   count,
    output logic                           overflow,
    output logic                           underflow,
    output logic                           ovf_sticky,
    output logic                           udf_sticky
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = cnt_w(DEPTH_LOG2);
    localparam int AW    = DEPTH_LOG2;

    if (!params_ok(DEPTH_LOG2, AF_THRESH, AE_THRESH, FWFT)) begin : g_bad_params
        $error("fifo_sync_param: illegal DEPTH_LOG2/threshold/FWFT combination");
    end

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             ovf_st_q, ovf_st_d;
    logic             udf_st_q, udf_st_d;
    logic             rd_accept;
    logic             wr_accept;
    logic [WIDTH-1:0] ram_rdata;

    // Flags are decoded from the registered count only.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));

    // A read frees a slot on the same edge, so a full FIFO can take a write
    // alongside an accepted read.
    assign rd_accept = rd_en & ~empty;
    assign wr_accept = wr_en & (~full | rd_accept);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d    = wr_en & ~wr_accept;
        udf_d    = rd_en & ~rd_accept;
        // Set dominates clear when both happen on the same edge.
        ovf_st_d = (ovf_st_q & ~clr_err) | ovf_d;
        udf_st_d = (udf_st_q & ~clr_err) | udf_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            ovf_st_q <= 1'b0;
            udf_st_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            ovf_st_q <= ovf_st_d;
            udf_st_q <= udf_st_d;
        end
    end

    fifo_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_accept & reset_n),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    if (FWFT == FWFT_ON) begin : g_fwft
        // Head of the queue is always visible; a pop exposes the next entry.
        assign data_o  = ram_rdata;
        assign valid_o = ~empty;
    end else begin : g_std
        logic [WIDTH-1:0] data_q, data_d;
        logic             valid_q, valid_d;

        always_comb begin
            data_d  = data_q;
            valid_d = 1'b0;
            if (rd_accept) begin
                data_d  = ram_rdata;
                valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign data_o  = data_q;
        assign valid_o = valid_q;
    end

    assign count      = count_q;
    assign overflow   = ovf_q;
    assign underflow  = udf_q;
    assign ovf_sticky = ovf_st_q;
    assign udf_sticky = udf_st_q;

endmodule
